// File: rtl/bc_pkg.sv
// Shared constants and helpers for the Basic Computer I/O and interrupt unit.
// Holds default widths, the default vector base and the channel priority encoder.
package bc_pkg;

    localparam int BC_ADDR_W = 12;
    localparam int BC_WORD_W = 16;
    localparam int BC_IO_W   = 8;
    localparam int BC_MAX_CH = 8;
    localparam int BC_IDX_W  = 3;

    localparam logic [BC_ADDR_W-1:0] BC_VEC_BASE = 12'h001;

    typedef struct packed {
        logic [BC_IDX_W-1:0] idx;
        logic                vld;
    } bc_prio_t;

    // Lowest set bit wins; vld reports whether any bit was set.
    function automatic bc_prio_t bc_prio_enc(input logic [BC_MAX_CH-1:0] req);
        bc_prio_t res;
        res.idx = '0;
        res.vld = 1'b0;
        for (int i = BC_MAX_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                res.idx = BC_IDX_W'(i);
                res.vld = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bc_io_channel.sv
// One I/O channel: INPR/OUTR registers, FGI/FGO flags and device handshakes.
// A held input byte is never overwritten until INP has cleared FGI.
module bc_io_channel
    import bc_pkg::*;
#(
    parameter int DATA_W = BC_IO_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    input  logic              inp_clr_i,
    input  logic              out_ld_i,
    input  logic [DATA_W-1:0] ac_low_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] inpr_o,
    output logic              fgi_o,
    output logic              fgo_o
);

    logic [DATA_W-1:0] inpr_q, inpr_d;
    logic [DATA_W-1:0] outr_q, outr_d;
    logic              fgi_q, fgi_d;
    logic              fgo_q, fgo_d;
    logic              ov_q, ov_d;

    // Next-state for both directions of the channel.
    always_comb begin
        inpr_d = inpr_q;
        outr_d = outr_q;
        fgi_d  = fgi_q;
        fgo_d  = fgo_q;
        ov_d   = ov_q;
        if (in_valid_i && !fgi_q) begin
            inpr_d = in_data_i;
            fgi_d  = 1'b1;
        end else if (inp_clr_i) begin
            fgi_d = 1'b0;
        end
        if (out_ld_i && fgo_q) begin
            outr_d = ac_low_i;
            fgo_d  = 1'b0;
            ov_d   = 1'b1;
        end else if (ov_q && out_ready_i) begin
            ov_d  = 1'b0;
            fgo_d = 1'b1;
        end
    end

    // Channel state registers; FGO idles high so the device looks ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inpr_q <= '0;
            outr_q <= '0;
            fgi_q  <= 1'b0;
            fgo_q  <= 1'b1;
            ov_q   <= 1'b0;
        end else begin
            inpr_q <= inpr_d;
            outr_q <= outr_d;
            fgi_q  <= fgi_d;
            fgo_q  <= fgo_d;
            ov_q   <= ov_d;
        end
    end

    assign in_ready_o  = ~fgi_q;
    assign out_valid_o = ov_q;
    assign out_data_o  = outr_q;
    assign inpr_o      = inpr_q;
    assign fgi_o       = fgi_q;
    assign fgo_o       = fgo_q;

endmodule

// File: rtl/bc_io_intr_unit.sv
// Multi-channel I/O and interrupt unit: IEN, R flag and vectored return address.
// Optional interrupt mask register enabled by defining BC_IO_IMSK_EN.
module bc_io_intr_unit
    import bc_pkg::*;
#(
    parameter int                NUM_CH   = 2,
    parameter int                DATA_W   = BC_IO_W,
    parameter int                ADDR_W   = BC_ADDR_W,
    parameter logic [ADDR_W-1:0] VEC_BASE = ADDR_W'(BC_VEC_BASE),
    localparam int               SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        dev_in_valid,
    input  logic [NUM_CH*DATA_W-1:0] dev_in_data,
    output logic [NUM_CH-1:0]        dev_in_ready,
    output logic [NUM_CH-1:0]        dev_out_valid,
    output logic [NUM_CH*DATA_W-1:0] dev_out_data,
    input  logic [NUM_CH-1:0]        dev_out_ready,
    input  logic [SEL_W-1:0]         ch_sel,
    input  logic                     inp_stb,
    input  logic                     out_stb,
    input  logic [DATA_W-1:0]        ac_low,
    output logic [DATA_W-1:0]        inpr_data,
    output logic                     ski,
    output logic                     sko,
    input  logic                     ion_stb,
    input  logic                     iof_stb,
    input  logic                     fetch_idle,
    input  logic                     int_ack,
    output logic                     ien,
    output logic                     r_flag,
    output logic [ADDR_W-1:0]        int_vec,
    output logic [NUM_CH-1:0]        fgi,
    output logic [NUM_CH-1:0]        fgo
`ifdef BC_IO_IMSK_EN
    ,
    input  logic                     msk_we,
    input  logic [2*NUM_CH-1:0]      msk_data
`endif
);

    logic                    sel_ok;
    logic [NUM_CH-1:0]       inp_clr;
    logic [NUM_CH-1:0]       out_ld;
    logic [DATA_W-1:0]       inpr_arr [NUM_CH];
    logic [NUM_CH-1:0]       req;
    logic [BC_MAX_CH-1:0]    req_ext;
    bc_prio_t                prio;
    logic                    pend;
    logic [ADDR_W-1:0]       vec_calc;
    logic                    ien_q, ien_d;
    logic                    r_q, r_d;
    logic [ADDR_W-1:0]       vec_q, vec_d;

    assign sel_ok = (int'(ch_sel) < NUM_CH);

    // Per-channel strobe decode and readback muxes; bad selects read zero.
    always_comb begin
        inp_clr   = '0;
        out_ld    = '0;
        inpr_data = '0;
        ski       = 1'b0;
        sko       = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (sel_ok && (ch_sel == SEL_W'(k))) begin
                inp_clr[k] = inp_stb;
                out_ld[k]  = out_stb;
                inpr_data  = inpr_arr[k];
                ski        = fgi[k];
                sko        = fgo[k];
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        bc_io_channel #(
            .DATA_W (DATA_W)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .in_valid_i  (dev_in_valid[k]),
            .in_data_i   (dev_in_data[k*DATA_W +: DATA_W]),
            .in_ready_o  (dev_in_ready[k]),
            .inp_clr_i   (inp_clr[k]),
            .out_ld_i    (out_ld[k]),
            .ac_low_i    (ac_low),
            .out_valid_o (dev_out_valid[k]),
            .out_data_o  (dev_out_data[k*DATA_W +: DATA_W]),
            .out_ready_i (dev_out_ready[k]),
            .inpr_o      (inpr_arr[k]),
            .fgi_o       (fgi[k]),
            .fgo_o       (fgo[k])
        );
    end

`ifdef BC_IO_IMSK_EN
    logic [2*NUM_CH-1:0] imsk_q, imsk_d;

    // Mask register load; a 1 bit lets the matching flag request.
    always_comb begin
        imsk_d = msk_we ? msk_data : imsk_q;
    end

    // Mask register starts fully enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imsk_q <= '1;
        end else begin
            imsk_q <= imsk_d;
        end
    end

    assign req = (fgi & imsk_q[NUM_CH-1:0])
               | (fgo & imsk_q[2*NUM_CH-1:NUM_CH]);
`else
    assign req = fgi | fgo;
`endif

    // Pending reduction and vector for the lowest pending channel.
    always_comb begin
        req_ext             = '0;
        req_ext[NUM_CH-1:0] = req;
        prio                = bc_prio_enc(req_ext);
        pend                = prio.vld;
        vec_calc            = VEC_BASE + ADDR_W'({prio.idx, 1'b0});
    end

    // IEN, R and vector next-state; int_ack overrides everything.
    always_comb begin
        ien_d = ien_q;
        r_d   = r_q;
        vec_d = vec_q;
        if (int_ack) begin
            ien_d = 1'b0;
            r_d   = 1'b0;
        end else begin
            if (iof_stb) begin
                ien_d = 1'b0;
            end else if (ion_stb) begin
                ien_d = 1'b1;
            end
            if (ien_q && fetch_idle && pend && !r_q) begin
                r_d   = 1'b1;
                vec_d = vec_calc;
            end
        end
    end

    // Interrupt control registers; the vector is captured only as R rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ien_q <= 1'b0;
            r_q   <= 1'b0;
            vec_q <= '0;
        end else begin
            ien_q <= ien_d;
            r_q   <= r_d;
            vec_q <= vec_d;
        end
    end

    assign ien     = ien_q;
    assign r_flag  = r_q;
    assign int_vec = vec_q;

endmodule

// File: tb/tb_bc_io_intr_unit.sv
// Scoreboard bench for bc_io_intr_unit (NUM_CH=2 plus a NUM_CH=3 copy).
// Stimulus queues expectations; a negedge monitor pops and compares them.
module tb_bc_io_intr_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  dev_in_valid = '0;
    logic [15:0] dev_in_data = '0;
    logic [1:0]  dev_in_ready;
    logic [1:0]  dev_out_valid;
    logic [15:0] dev_out_data;
    logic [1:0]  dev_out_ready = '0;
    logic [0:0]  ch_sel = '0;
    logic        inp_stb = 1'b0;
    logic        out_stb = 1'b0;
    logic [7:0]  ac_low = '0;
    logic [7:0]  inpr_data;
    logic        ski, sko;
    logic        ion_stb = 1'b0;
    logic        iof_stb = 1'b0;
    logic        fetch_idle = 1'b0;
    logic        int_ack = 1'b0;
    logic        ien, r_flag;
    logic [11:0] int_vec;
    logic [1:0]  fgi, fgo;

    logic [2:0]  d3_in_ready, d3_out_valid;
    logic [23:0] d3_out_data;
    logic [1:0]  d3_sel = '0;
    logic        d3_inp = 1'b0;
    logic        d3_out = 1'b0;
    logic [7:0]  d3_inpr;
    logic        d3_ski, d3_sko;
    logic        d3_ien, d3_r;
    logic [11:0] d3_vec;
    logic [2:0]  d3_fgi, d3_fgo;

    always #5 clk = ~clk;

    bc_io_intr_unit #(.NUM_CH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .dev_in_valid(dev_in_valid), .dev_in_data(dev_in_data),
        .dev_in_ready(dev_in_ready), .dev_out_valid(dev_out_valid),
        .dev_out_data(dev_out_data), .dev_out_ready(dev_out_ready),
        .ch_sel(ch_sel), .inp_stb(inp_stb), .out_stb(out_stb),
        .ac_low(ac_low), .inpr_data(inpr_data), .ski(ski), .sko(sko),
        .ion_stb(ion_stb), .iof_stb(iof_stb), .fetch_idle(fetch_idle),
        .int_ack(int_ack), .ien(ien), .r_flag(r_flag),
        .int_vec(int_vec), .fgi(fgi), .fgo(fgo)
    );

    bc_io_intr_unit #(.NUM_CH(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .dev_in_valid(3'b000), .dev_in_data(24'h0),
        .dev_in_ready(d3_in_ready), .dev_out_valid(d3_out_valid),
        .dev_out_data(d3_out_data), .dev_out_ready(3'b000),
        .ch_sel(d3_sel), .inp_stb(d3_inp), .out_stb(d3_out),
        .ac_low(8'h5E), .inpr_data(d3_inpr), .ski(d3_ski), .sko(d3_sko),
        .ion_stb(1'b0), .iof_stb(1'b0), .fetch_idle(1'b0),
        .int_ack(1'b0), .ien(d3_ien), .r_flag(d3_r),
        .int_vec(d3_vec), .fgi(d3_fgi), .fgo(d3_fgo)
    );

    typedef struct {
        int          cyc;
        int          id;
        logic [31:0] val;
    } exp_t;

    exp_t       q[$];
    logic [7:0] out_q[$];
    logic [7:0] in_q[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] obs(int id);
        case (id)
            0:  return 32'(fgi);
            1:  return 32'(fgo);
            2:  return 32'(ien);
            3:  return 32'(r_flag);
            4:  return 32'(dev_out_valid);
            5:  return 32'(dev_in_ready);
            6:  return 32'(ski);
            7:  return 32'(sko);
            8:  return 32'(inpr_data);
            9:  return 32'(int_vec);
            10: return 32'(dev_out_data[7:0]);
            11: return 32'(d3_fgi);
            12: return 32'(d3_fgo);
            13: return 32'(d3_sko);
            14: return 32'(d3_ski);
            15: return 32'(d3_inpr);
            default: return 32'hDEAD;
        endcase
    endfunction

    function automatic string nm(int id);
        case (id)
            0:  return "fgi";
            1:  return "fgo";
            2:  return "ien";
            3:  return "r_flag";
            4:  return "dev_out_valid";
            5:  return "dev_in_ready";
            6:  return "ski";
            7:  return "sko";
            8:  return "inpr_data";
            9:  return "int_vec";
            10: return "dev_out_data0";
            11: return "d3_fgi";
            12: return "d3_fgo";
            13: return "d3_sko";
            14: return "d3_ski";
            15: return "d3_inpr";
            default: return "unknown";
        endcase
    endfunction

    task automatic ex(int dly, int id, logic [31:0] v);
        exp_t e;
        e.cyc = cyc + dly;
        e.id  = id;
        e.val = v;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare due expectations and device-side transfers.
    always @(negedge clk) begin
        int i;
        logic [31:0] got;
        logic [7:0]  want;
        i = 0;
        while (i < q.size()) begin
            if (q[i].cyc <= cyc) begin
                checks++;
                got = obs(q[i].id);
                if (q[i].cyc < cyc) begin
                    errors++;
                    $display("FAIL %s stale cyc=%0d", nm(q[i].id), q[i].cyc);
                end else if (got !== q[i].val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got %0h expected %0h",
                             nm(q[i].id), cyc, got, q[i].val);
                end
                q.delete(i);
            end else begin
                i++;
            end
        end
        if (dev_out_valid[0] && dev_out_ready[0]) begin
            checks++;
            if (out_q.size() == 0) begin
                errors++;
                $display("FAIL out_xfer cyc=%0d got %0h expected none",
                         cyc, dev_out_data[7:0]);
            end else begin
                want = out_q.pop_front();
                if (dev_out_data[7:0] !== want) begin
                    errors++;
                    $display("FAIL out_xfer cyc=%0d got %0h expected %0h",
                             cyc, dev_out_data[7:0], want);
                end
            end
        end
        if (inp_stb) begin
            checks++;
            if (in_q.size() == 0) begin
                errors++;
                $display("FAIL inp_read cyc=%0d got %0h expected none",
                         cyc, inpr_data);
            end else begin
                want = in_q.pop_front();
                if (inpr_data !== want) begin
                    errors++;
                    $display("FAIL inp_read cyc=%0d got %0h expected %0h",
                             cyc, inpr_data, want);
                end
            end
        end
    end

    initial begin
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Build a transfer in flight, then reset asynchronously.
        ion_stb = 1'b1; out_stb = 1'b1; ch_sel = 1'b0; ac_low = 8'h11;
        dev_in_valid = 2'b10; dev_in_data = 16'h7700;
        tick();
        ion_stb = 1'b0; out_stb = 1'b0; dev_in_valid = 2'b00;
        ex(0, 2, 1); ex(0, 4, 2'b01); ex(0, 0, 2'b10); ex(0, 1, 2'b10);
        tick();
        rst_n = 1'b0;
        ex(0, 1, 2'b11); ex(0, 0, 2'b00); ex(0, 2, 0);
        ex(0, 3, 0); ex(0, 4, 2'b00); ex(0, 12, 3'b111); ex(0, 11, 3'b000);
        tick();
        rst_n = 1'b1;
        tick();

        // Input channel 1 accept and INP read.
        dev_in_valid = 2'b10; dev_in_data = 16'hA500;
        ex(0, 5, 2'b11);
        tick();
        dev_in_valid = 2'b00; ch_sel = 1'b1;
        ex(0, 0, 2'b10); ex(0, 5, 2'b01); ex(0, 6, 1);
        tick();
        inp_stb = 1'b1; in_q.push_back(8'hA5);
        tick();
        inp_stb = 1'b0;
        ex(0, 0, 2'b00); ex(0, 6, 0);
        tick();

        // Output channel 0 with a stalled device.
        ch_sel = 1'b0; out_stb = 1'b1; ac_low = 8'h3C;
        out_q.push_back(8'h3C);
        tick();
        out_stb = 1'b0;
        ex(0, 10, 8'h3C); ex(0, 7, 0);
        for (int i = 0; i < 5; i++) begin
            ex(0, 1, 2'b10); ex(0, 4, 2'b01);
            if (i == 1) begin
                out_stb = 1'b1; ac_low = 8'hFF;
            end else begin
                out_stb = 1'b0;
            end
            tick();
        end
        out_stb = 1'b0;
        dev_out_ready = 2'b01;
        tick();
        dev_out_ready = 2'b00;
        ex(0, 1, 2'b11); ex(0, 4, 2'b00); ex(0, 7, 1);
        tick();

        // Interrupt on channel 1 input, then collision cases.
        ion_stb = 1'b1; out_stb = 1'b1; ch_sel = 1'b0; ac_low = 8'h5A;
        out_q.push_back(8'h5A);
        dev_in_valid = 2'b10; dev_in_data = 16'hC300;
        tick();
        ion_stb = 1'b0; out_stb = 1'b0; dev_in_valid = 2'b00;
        fetch_idle = 1'b1; ch_sel = 1'b1;
        ex(0, 2, 1); ex(0, 1, 2'b10); ex(0, 0, 2'b10); ex(0, 3, 0);
        tick();
        ex(0, 3, 1); ex(0, 9, 12'h003);
        inp_stb = 1'b1; in_q.push_back(8'hC3);
        tick();
        inp_stb = 1'b0;
        ex(0, 3, 1); ex(0, 9, 12'h003); ex(0, 0, 2'b00);
        int_ack = 1'b1; ion_stb = 1'b1;
        tick();
        int_ack = 1'b0; ion_stb = 1'b0;
        ex(0, 2, 0); ex(0, 3, 0);
        tick();
        ex(0, 3, 0);
        ion_stb = 1'b1; iof_stb = 1'b1; dev_out_ready = 2'b01;
        tick();
        ion_stb = 1'b0; iof_stb = 1'b0; dev_out_ready = 2'b00;
        ex(0, 2, 0); ex(0, 1, 2'b11); ex(0, 4, 2'b00); ex(0, 3, 0);
        ion_stb = 1'b1;
        tick();
        ion_stb = 1'b0;
        ex(0, 2, 1); ex(0, 3, 0);
        tick();
        ex(0, 3, 1); ex(0, 9, 12'h001);
        int_ack = 1'b1; fetch_idle = 1'b0;
        tick();
        int_ack = 1'b0;
        ex(0, 3, 0); ex(0, 2, 0);
        tick();

        // INP and a new byte in the same cycle while FGI is set.
        dev_in_valid = 2'b10; dev_in_data = 16'h1100;
        tick();
        ex(0, 0, 2'b10); ex(0, 8, 8'h11);
        dev_in_data = 16'h2200;
        inp_stb = 1'b1; in_q.push_back(8'h11);
        tick();
        inp_stb = 1'b0;
        ex(0, 0, 2'b00); ex(0, 8, 8'h11); ex(0, 5, 2'b11);
        tick();
        dev_in_valid = 2'b00;
        ex(0, 0, 2'b10); ex(0, 6, 1); ex(0, 8, 8'h22);
        inp_stb = 1'b1; in_q.push_back(8'h22);
        tick();
        inp_stb = 1'b0;
        ex(0, 0, 2'b00);
        tick();

        // Out-of-range select on the three-channel copy.
        d3_sel = 2'd3; d3_out = 1'b1; d3_inp = 1'b1;
        ex(0, 13, 0); ex(0, 14, 0); ex(0, 15, 0); ex(0, 12, 3'b111);
        tick();
        d3_out = 1'b0; d3_inp = 1'b0; d3_sel = 2'd2;
        ex(0, 12, 3'b111); ex(0, 11, 3'b000); ex(0, 13, 1);
        tick();
        tick();
        tick();

        checks++;
        if (q.size() != 0 || out_q.size() != 0 || in_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d/%0d/%0d expected 0/0/0",
                     q.size(), out_q.size(), in_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
